// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; WIDTH cycles accept-to-done, divide-by-zero finishes on the accepting edge.
// Single-operation engine: start is only sampled while ready is high, and a start seen while busy is ignored rather than queued.
// Results persist in quotient/remainder/div_by_zero until the next operation completes.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    // The partial remainder stays below D after every restore, so its top bit
    // is always zero and is not stored; the trial difference is still WIDTH+1 bits.
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   s_val;
    logic [WIDTH:0]   t_val;
    logic             borrow;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;
    logic             accept;
    logic             last_step;

    always_comb begin
        s_val  = {r_reg, q_reg[WIDTH-1]};
        t_val  = s_val - {1'b0, d_reg};
        borrow = t_val[WIDTH];
        r_step = borrow ? s_val[WIDTH-1:0] : t_val[WIDTH-1:0];
        q_step = {q_reg[WIDTH-2:0], ~borrow};
    end

    assign accept    = (state_q == IDLE) && start;
    assign last_step = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (state_q)
            IDLE:    ready = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            cnt   <= CW'(WIDTH);
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state_q == RUN) begin
            q_reg <= q_step;
            r_reg <= r_step;
            cnt   <= cnt - CW'(1);
            // Result registers only move on the edge that enters DONE.
            if (last_step) begin
                quotient    <= q_step;
                remainder   <= r_step;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results at accept,
// a negedge monitor pops them on done and checks values, latency and result hold.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .ready      (ready),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] hold_q = '0;
    logic [W-1:0] hold_r = '0;
    logic         hold_z = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Latency is counted in edges from the accepting edge to the edge that raises done;
    // a zero divisor raises done on the accepting edge itself.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        while (!ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        sb.push_back('{a, b, eq, er, ez, cyc, (b == 0) ? 0 : W});
        chk("ready_drop", ready, 0);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_q = '0;
            hold_r = '0;
            hold_z = 1'b0;
        end
        chk("ready_done_excl", ready && done, 0);
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", quotient, mon_e.q);
                chk("remainder", remainder, mon_e.r);
                chk("div_by_zero", div_by_zero, mon_e.z);
                chk("latency", cyc - mon_e.acc, mon_e.lat);
                if (!mon_e.z) begin
                    chk("identity", int'(quotient) * int'(mon_e.b) + int'(remainder), mon_e.a);
                    chk("rem_lt_div", remainder < mon_e.b, 1);
                end
                hold_q = mon_e.q;
                hold_r = mon_e.r;
                hold_z = mon_e.z;
            end
        end else begin
            chk("hold_quotient", quotient, hold_q);
            chk("hold_remainder", remainder, hold_r);
            chk("hold_dbz", div_by_zero, hold_z);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           guard;

        #12;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic divide
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

        // Boundary operands, back to back
        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);

        // Divide by zero, then a normal op clears the flag
        issue(8'd37, 8'd0, 8'd255, 8'd37, 1'b1);
        issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);

        // start held high with new operands throughout the busy window
        issue(8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
        start    = 1'b1;
        dividend = 8'd10;
        divisor  = 8'd2;
        issue(8'd10, 8'd2, 8'd5, 8'd0, 1'b0);

        // Reset four steps into RUN, asserted mid-cycle
        issue(8'd150, 8'd4, 8'd37, 8'd2, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_dbz", div_by_zero, 0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        issue(8'd150, 8'd4, 8'd37, 8'd2, 1'b0);

        // Random regression including zero divisors
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            if (b == 0) issue(a, b, 8'd255, a, 1'b1);
            else        issue(a, b, a / b, a % b, 1'b0);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        chk("drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
